// File: rtl/dbus_arbiter_if.sv
// CPU-side data port bundle (req/gnt/rvalid protocol).
// req/gnt: a request is accepted in the cycle where req and gnt are both high;
// rvalid is a single-cycle response pulse with no back-pressure.
interface dbus_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master arbiter sharing one data port; one outstanding transaction,
// responses routed to the issuing master, hung accesses end in a timeout error.
module dbus_arbiter #(
    parameter int          ARB_MODE  = 0,
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    dbus_arbiter_if.slave        m0,
    dbus_arbiter_if.slave        m1,
    dbus_arbiter_if.master       s,
    output logic                 busy,
    output logic                 owner,
    output logic                 timeout_evt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          win;
    logic          sel;
    logic          s_req_c;
    logic          gnt0, gnt1;
    logic          rsp;
    logic          rsp_err;
    logic [31:0]   rsp_data;
    logic          tmo_c;
    logic          tmo_hit;
    logic          live;

    // Outputs are forced to zero while Rst is held, independent of the clock.
    assign live    = ~Rst;
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == TMO_LAST);

    always_comb begin
        win = 1'b0;
        if (m1.req && !m0.req) begin
            win = 1'b1;
        end else if (m0.req && m1.req) begin
            win = (ARB_MODE == 1) ? 1'b0 : ~last_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sel      = win;
        s_req_c  = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rsp      = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        tmo_c    = 1'b0;
        case (state_q)
            IDLE: begin
                sel     = win;
                s_req_c = win ? m1.req : m0.req;
                if (s_req_c && s.gnt) begin
                    gnt0    = ~win;
                    gnt1    = win;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                sel   = owner_q;
                cnt_d = cnt_q + 1'b1;
                // A real response in the timeout cycle takes precedence.
                if (s.rvalid) begin
                    rsp      = 1'b1;
                    rsp_err  = s.err;
                    rsp_data = s.rdata;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    rsp      = 1'b1;
                    rsp_err  = 1'b1;
                    rsp_data = ERR_RDATA;
                    tmo_c    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s.req   = live & s_req_c;
    assign s.we    = live & (sel ? m1.we : m0.we);
    assign s.be    = live ? (sel ? m1.be : m0.be) : '0;
    assign s.addr  = live ? (sel ? m1.addr : m0.addr) : '0;
    assign s.wdata = live ? (sel ? m1.wdata : m0.wdata) : '0;

    assign m0.gnt    = live & gnt0;
    assign m1.gnt    = live & gnt1;
    assign m0.rvalid = live & rsp & ~owner_q;
    assign m1.rvalid = live & rsp & owner_q;
    assign m0.err    = live & rsp & ~owner_q & rsp_err;
    assign m1.err    = live & rsp & owner_q & rsp_err;
    assign m0.rdata  = (live && rsp && !owner_q) ? rsp_data : '0;
    assign m1.rdata  = (live && rsp && owner_q) ? rsp_data : '0;

    assign busy        = live & (state_q == WAIT_RSP);
    assign owner       = live & owner_q;
    assign timeout_evt = live & tmo_c;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench: a round-robin and a fixed-priority instance share stimulus
// and are each checked against a transaction-level reference model.
module tb_dbus_arbiter;

  localparam int          TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int          NCYC = 4000;

  typedef struct packed {
    logic        m0_gnt;
    logic        m0_rvalid;
    logic        m0_err;
    logic [31:0] m0_rdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic        m1_err;
    logic [31:0] m1_rdata;
    logic        s_req;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        busy;
    logic        owner;
    logic        tmo;
  } out_t;

  // clock / reset
  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  // shared stimulus
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_gnt, s_rvalid, s_err;
  logic [31:0] s_rdata;

  int n_vec = 0;
  int n_err = 0;

  dbus_arbiter_if ia_m0 ();
  dbus_arbiter_if ia_m1 ();
  dbus_arbiter_if ia_s ();
  dbus_arbiter_if ib_m0 ();
  dbus_arbiter_if ib_m1 ();
  dbus_arbiter_if ib_s ();

  logic a_busy, a_owner, a_tmo, b_busy, b_owner, b_tmo;

  assign ia_m0.req = m0_req;   assign ib_m0.req = m0_req;
  assign ia_m0.we = m0_we;     assign ib_m0.we = m0_we;
  assign ia_m0.be = m0_be;     assign ib_m0.be = m0_be;
  assign ia_m0.addr = m0_addr; assign ib_m0.addr = m0_addr;
  assign ia_m0.wdata = m0_wdata; assign ib_m0.wdata = m0_wdata;
  assign ia_m1.req = m1_req;   assign ib_m1.req = m1_req;
  assign ia_m1.we = m1_we;     assign ib_m1.we = m1_we;
  assign ia_m1.be = m1_be;     assign ib_m1.be = m1_be;
  assign ia_m1.addr = m1_addr; assign ib_m1.addr = m1_addr;
  assign ia_m1.wdata = m1_wdata; assign ib_m1.wdata = m1_wdata;
  assign ia_s.gnt = s_gnt;     assign ib_s.gnt = s_gnt;
  assign ia_s.rvalid = s_rvalid; assign ib_s.rvalid = s_rvalid;
  assign ia_s.rdata = s_rdata; assign ib_s.rdata = s_rdata;
  assign ia_s.err = s_err;     assign ib_s.err = s_err;

  dbus_arbiter #(.ARB_MODE(0), .TIMEOUT(TMO), .ERR_RDATA(ERRD)) dut_rr (
    .Clk(Clk), .Rst(rst), .m0(ia_m0), .m1(ia_m1), .s(ia_s),
    .busy(a_busy), .owner(a_owner), .timeout_evt(a_tmo)
  );

  dbus_arbiter #(.ARB_MODE(1), .TIMEOUT(TMO), .ERR_RDATA(ERRD)) dut_fp (
    .Clk(Clk), .Rst(rst), .m0(ib_m0), .m1(ib_m1), .s(ib_s),
    .busy(b_busy), .owner(b_owner), .timeout_evt(b_tmo)
  );

  out_t obs_a, obs_b;
  assign obs_a = '{m0_gnt: ia_m0.gnt, m0_rvalid: ia_m0.rvalid, m0_err: ia_m0.err,
                   m0_rdata: ia_m0.rdata, m1_gnt: ia_m1.gnt, m1_rvalid: ia_m1.rvalid,
                   m1_err: ia_m1.err, m1_rdata: ia_m1.rdata, s_req: ia_s.req,
                   s_we: ia_s.we, s_be: ia_s.be, s_addr: ia_s.addr, s_wdata: ia_s.wdata,
                   busy: a_busy, owner: a_owner, tmo: a_tmo};
  assign obs_b = '{m0_gnt: ib_m0.gnt, m0_rvalid: ib_m0.rvalid, m0_err: ib_m0.err,
                   m0_rdata: ib_m0.rdata, m1_gnt: ib_m1.gnt, m1_rvalid: ib_m1.rvalid,
                   m1_err: ib_m1.err, m1_rdata: ib_m1.rdata, s_req: ib_s.req,
                   s_we: ib_s.we, s_be: ib_s.be, s_addr: ib_s.addr, s_wdata: ib_s.wdata,
                   busy: b_busy, owner: b_owner, tmo: b_tmo};

  // reference model: one outstanding transaction per instance (0 = round-robin, 1 = fixed)
  bit m_busy [2];
  bit m_own  [2];
  bit m_last [2];
  int m_age  [2];
  int n_grant [2][2];
  int n_tmo   [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0;
    m_own[k]  = 1'b0;
    m_last[k] = 1'b1;
    m_age[k]  = 0;
  endtask

  // Expected outputs for this cycle's inputs, then advance to the next cycle.
  task automatic model_step(input int k, output out_t e);
    bit w;
    bit any;
    bit resp;
    logic [31:0] d;
    logic er;
    e = '0;
    if (rst) begin
      model_reset(k);
      return;
    end
    e.busy  = m_busy[k];
    e.owner = m_own[k];
    if (!m_busy[k]) begin
      any = m0_req | m1_req;
      if (m0_req && m1_req) w = (k == 1) ? 1'b0 : ~m_last[k];
      else                  w = m1_req;
      e.s_req = any;
      if (any && s_gnt) begin
        if (w) e.m1_gnt = 1'b1;
        else   e.m0_gnt = 1'b1;
        n_grant[k][w]++;
        m_busy[k] = 1'b1;
        m_own[k]  = w;
        m_last[k] = w;
        m_age[k]  = 0;
      end
    end else begin
      w = m_own[k];
      resp = s_rvalid || (m_age[k] == TMO - 1);
      if (resp) begin
        d  = s_rvalid ? s_rdata : ERRD;
        er = s_rvalid ? s_err : 1'b1;
        e.tmo = ~s_rvalid;
        if (!s_rvalid) n_tmo[k]++;
        if (w) begin e.m1_rvalid = 1'b1; e.m1_rdata = d; e.m1_err = er; end
        else   begin e.m0_rvalid = 1'b1; e.m0_rdata = d; e.m0_err = er; end
        m_busy[k] = 1'b0;
      end else begin
        m_age[k]++;
      end
    end
    e.s_we    = w ? m1_we : m0_we;
    e.s_be    = w ? m1_be : m0_be;
    e.s_addr  = w ? m1_addr : m0_addr;
    e.s_wdata = w ? m1_wdata : m0_wdata;
    if (rst) begin
      e.s_we = 1'b0; e.s_be = '0; e.s_addr = '0; e.s_wdata = '0;
    end
  endtask

  task automatic check_dut(input int k, input out_t o, input out_t e, input int cyc);
    string p;
    p = $sformatf("%s c%0d", (k == 0) ? "rr" : "fp", cyc);
    check_eq({p, " m0_gnt"},    64'(o.m0_gnt),    64'(e.m0_gnt));
    check_eq({p, " m0_rvalid"}, 64'(o.m0_rvalid), 64'(e.m0_rvalid));
    check_eq({p, " m0_err"},    64'(o.m0_err),    64'(e.m0_err));
    check_eq({p, " m0_rdata"},  64'(o.m0_rdata),  64'(e.m0_rdata));
    check_eq({p, " m1_gnt"},    64'(o.m1_gnt),    64'(e.m1_gnt));
    check_eq({p, " m1_rvalid"}, 64'(o.m1_rvalid), 64'(e.m1_rvalid));
    check_eq({p, " m1_err"},    64'(o.m1_err),    64'(e.m1_err));
    check_eq({p, " m1_rdata"},  64'(o.m1_rdata),  64'(e.m1_rdata));
    check_eq({p, " s_req"},     64'(o.s_req),     64'(e.s_req));
    check_eq({p, " s_we"},      64'(o.s_we),      64'(e.s_we));
    check_eq({p, " s_be"},      64'(o.s_be),      64'(e.s_be));
    check_eq({p, " s_addr"},    64'(o.s_addr),    64'(e.s_addr));
    check_eq({p, " s_wdata"},   64'(o.s_wdata),   64'(e.s_wdata));
    check_eq({p, " busy"},      64'(o.busy),      64'(e.busy));
    check_eq({p, " owner"},     64'(o.owner),     64'(e.owner));
    check_eq({p, " timeout_evt"}, 64'(o.tmo),     64'(e.tmo));
  endtask

  // driver: phase selects request density and slave response behaviour
  task automatic drive_random(input int ph);
    int rv_pct;
    m0_we    = 1'($urandom);
    m1_we    = 1'($urandom);
    m0_be    = 4'($urandom);
    m1_be    = 4'($urandom);
    m0_addr  = $urandom;
    m1_addr  = $urandom;
    m0_wdata = $urandom;
    m1_wdata = $urandom;
    s_err    = ($urandom_range(0, 3) == 0);
    s_rdata  = $urandom;
    case (ph)
      1: begin m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; rv_pct = 60; end
      2: begin
           m0_req = ($urandom_range(0, 9) < 6); m1_req = ($urandom_range(0, 9) < 6);
           s_gnt = ($urandom_range(0, 9) < 8); rv_pct = 8;
         end
      3: begin
           m0_req = ($urandom_range(0, 9) < 3); m1_req = ($urandom_range(0, 9) < 7);
           s_gnt = 1'b1; rv_pct = 0;
         end
      default: begin
           m0_req = 1'($urandom); m1_req = 1'($urandom);
           s_gnt = ($urandom_range(0, 9) < 7); rv_pct = 40;
         end
    endcase
    s_rvalid = ($urandom_range(0, 99) < rv_pct);
  endtask

  initial begin
    out_t ea, eb;
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_be = 0; m1_be = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    s_gnt = 0; s_rvalid = 0; s_err = 0; s_rdata = 0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      n_tmo[k] = 0;
      n_grant[k][0] = 0;
      n_grant[k][1] = 0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge Clk);
      #1;
      if (cyc < 4) rst = 1'b1;
      else if (rst) rst = ($urandom_range(0, 1) == 0);
      else rst = ($urandom_range(0, 199) == 0);
      drive_random((cyc / 250) % 4);
      @(negedge Clk);
      model_step(0, ea);
      model_step(1, eb);
      check_dut(0, obs_a, ea, cyc);
      check_dut(1, obs_b, eb, cyc);
    end

    $display("rr grants m0=%0d m1=%0d timeouts=%0d; fp grants m0=%0d m1=%0d timeouts=%0d",
             n_grant[0][0], n_grant[0][1], n_tmo[0], n_grant[1][0], n_grant[1][1], n_tmo[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter in front of bus_mux. It shares the single CPU-side data port (req/gnt/rvalid protocol, addr/wdata/be) between the core data port (m0) and a second requester (m1), e.g. a DMA or debug loader.
- Allows one outstanding transaction at a time and routes each response back to the master that issued it.
- A response timeout converts a hung slave access into an error response.

Parameters:
- ARB_MODE, 0: 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins.
- TIMEOUT, 256: cycles in WAIT_RSP before a forced error response; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timeout response.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  master 0 request
- m0_we  in  1  master 0 write enable
- m0_be  in  4  master 0 byte enables
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  master 0 grant
- m0_rvalid  out  1  master 0 response valid
- m0_rdata  out  32  master 0 read data
- m0_err  out  1  master 0 error, qualified by m0_rvalid
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_*, for master 1
- s_req  out  1  request to bus_mux
- s_we  out  1  write enable to bus_mux
- s_be  out  4  byte enables to bus_mux
- s_addr  out  32  address to bus_mux
- s_wdata  out  32  write data to bus_mux
- s_gnt  in  1  grant from bus_mux
- s_rvalid  in  1  response valid from bus_mux
- s_rdata  in  32  read data from bus_mux
- s_err  in  1  error from bus_mux
- busy  out  1  high in WAIT_RSP
- owner  out  1  master owning the outstanding or last transaction
- timeout_evt  out  1  one-cycle pulse when a timeout fires

Behaviour:
- State machine: IDLE, WAIT_RSP. Registers: state, owner, last_winner, tmo_cnt [$clog2(TIMEOUT+1)-1:0].
- Reset values:
  - state = IDLE, owner = 0, last_winner = 1 (so m0 wins the first tie), tmo_cnt = 0.
  - All gnt/rvalid/err/timeout_evt = 0; s_req = 0; data outputs = 0.
- IDLE winner selection (combinational):
  - Only one req high: that master wins.
  - Both high, ARB_MODE=1: m0 wins.
  - Both high, ARB_MODE=0: the master that is not last_winner wins.
- IDLE bus drive:
  - s_req = winner's req.
  - s_we/s_be/s_addr/s_wdata = winner's fields, muxed combinationally.
  - With no req, s_* = m0 fields and s_req = 0.
- IDLE grant:
  - The winner's mX_gnt = s_gnt & s_req, in the same cycle. The loser's gnt = 0.
  - On a grant: owner <= winner, last_winner <= winner, tmo_cnt <= 0, state <= WAIT_RSP.
- Request withdrawal: a master dropping req before gnt is legal. Arbitration re-evaluates every IDLE cycle with no stored request state.
- WAIT_RSP:
  - s_req = 0 and both gnt = 0, so new requests stall.
  - s_* data fields keep the owner's values.
  - tmo_cnt increments each cycle.
- Response:
  - On s_rvalid in WAIT_RSP: owner's rvalid = 1, rdata = s_rdata, err = s_err, in the same cycle (zero added latency); state <= IDLE.
  - The non-owner's rvalid stays 0 and its rdata = 0.
  - Minimum turnaround: grant in cycle N, response no earlier than N+1, next grant no earlier than the response cycle + 1.
- Timeout (TIMEOUT>0):
  - If tmo_cnt == TIMEOUT-1 and s_rvalid = 0: owner's rvalid = 1, err = 1, rdata = ERR_RDATA; timeout_evt = 1; state <= IDLE.
  - If s_rvalid and the timeout coincide, the real response wins: err = s_err, timeout_evt = 0.
- Stray response: s_rvalid in IDLE is ignored and nothing is forwarded. TIMEOUT must exceed the worst-case slave latency; a late response after a timeout is not recovered.
- Back-to-back with ARB_MODE=0 and both masters holding req: grants alternate m0, m1, m0, ...
- Rst mid-transaction: immediate return to IDLE with reset values; a pending response is dropped.
- busy = (state == WAIT_RSP).

Test Plan:
- Single m0 read of 0x0000_1000 with bus_mux rvalid at +1 → m0_gnt in cycle N; m0_rvalid in N+1 with s_rdata=0x1234_5678; m1 signals stay 0.
- Both masters request continuously, ARB_MODE=0, 6 transactions → grant order m0,m1,m0,m1,m0,m1; each response goes to the correct owner (m0 rdata=0xA0.., m1 rdata=0xB0..).
- Both masters request, ARB_MODE=1 → m0 granted every time; m1_gnt stays 0 until m0_req drops, then m1 granted in the next IDLE cycle.
- TIMEOUT=8, slave never asserts rvalid → owner rvalid+err with rdata=0xDEAD_BEEF exactly 8 cycles after the grant cycle; timeout_evt pulses once; the next request is granted afterwards.
- s_rvalid in the same cycle as the timeout → normal response, err = s_err, no timeout_evt. Separately, a stray s_rvalid in IDLE → no mX_rvalid.
- Rst asserted during WAIT_RSP → all outputs 0 asynchronously; after release, a fresh m1 request is granted in its first cycle (last_winner=1 only matters when both request).
